rr_arbiter4: RTL and testbench

Four-way round-robin arbiter with bounded hold time. Samples four request lines, grants one requester at a time, and presents the winner as a registered 2-bit binary index plus a valid flag. It sits directly upstream of the team's 2-to-4 one-hot decoder: `grant_idx` feeds the decoder input, and the decoder output, qualified by `grant_valid`, forms the per-requester grant lines. A hold-time counter revokes a grant that is never released.

---
 rtl/rr_arbiter4_pkg.sv | 14 +
 rtl/rr_pick4.sv | 26 ++
 rtl/rr_arbiter4.sv | 72 +++++++
 tb/tb_rr_arbiter4.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter4_pkg.sv
// Shared constants and state encoding for the four-way round-robin arbiter.
// Imported by rr_pick4 and rr_arbiter4.
package rr_arbiter4_pkg;

  localparam int N_REQ        = 4;
  localparam int HOLD_MAX_DEF = 15;
  localparam int CNT_W_DEF    = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority pick: first set request scanning ptr, ptr+1, ... mod 4.
// Purely combinational; idx is meaningful only when any=1.
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [1:0]       ptr,
  input  logic [N_REQ-1:0] req,
  output logic [1:0]       idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [1:0]       off;

  always_comb begin
    // Rotate so that requester ptr lands on bit 0, then lowest-index wins.
    rot = N_REQ'({req, req} >> ptr);
    off = 2'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = 2'(i);
    end
    idx = off + ptr;
    any = |req;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with bounded hold; 1-cycle grant latency, all outputs registered.
// No backpressure: unlatched requests wait while a grant is held; one IDLE cycle between owners.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req3_req0,
  input  logic             done,
  output logic [1:0]       grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick_idx;
  logic             pick_any;
  logic             holder_req;
  logic             hold_expired;

  rr_pick4 u_pick (
    .ptr (ptr),
    .req (req3_req0),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign holder_req   = req3_req0[grant_idx];
  assign hold_expired = (HOLD_MAX != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= 2'd0;
      cnt         <= '0;
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            cnt         <= '0;
            state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          cnt <= cnt + CNT_W'(1);
          if (done || !holder_req || hold_expired) begin
            grant_valid <= 1'b0;
            ptr         <= grant_idx + 2'd1;
            state       <= ST_IDLE;
            // Only a pure expiry counts as forced; a release on the same edge wins.
            timeout     <= !done && holder_req && hold_expired;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: vector table, corner-case sequences, exhaustive rr_pick4 sweep
// and randomized traffic against a queue-free behavioural model.
module tb_rr_arbiter4;

  localparam int HM = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req3_req0 = 4'b0000;
  logic       done = 1'b0;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  logic [1:0] pk_ptr = 2'd0;
  logic [3:0] pk_req = 4'd0;
  logic [1:0] pk_idx;
  logic       pk_any;

  int n_chk  = 0;
  int n_fail = 0;

  rr_arbiter4 #(.HOLD_MAX(HM), .CNT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req3_req0   (req3_req0),
    .done        (done),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  rr_pick4 u_pick (
    .ptr (pk_ptr),
    .req (pk_req),
    .idx (pk_idx),
    .any (pk_any)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] req;
    logic       dn;
    logic       vld;
    logic [1:0] idx;
    logic       to;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(logic [3:0] r, logic d, logic v, logic [1:0] i, logic t);
    vec_t x;
    x.req = r; x.dn = d; x.vld = v; x.idx = i; x.to = t;
    return x;
  endfunction

  // First set bit scanning from p upward, modulo 4; -1 when none.
  function automatic int ref_pick(int p, logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  initial begin
    int hi;
    int holder;
    int m_ptr;
    int held;
    int w;
    logic [1:0] m_idx;
    logic m_to;

    vecs[0]  = mk(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    vecs[1]  = mk(4'b0100, 1'b1, 1'b0, 2'd2, 1'b0);
    vecs[2]  = mk(4'b1111, 1'b0, 1'b1, 2'd3, 1'b0);
    vecs[3]  = mk(4'b1111, 1'b1, 1'b0, 2'd3, 1'b0);
    vecs[4]  = mk(4'b1111, 1'b0, 1'b1, 2'd0, 1'b0);
    vecs[5]  = mk(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
    vecs[6]  = mk(4'b1111, 1'b0, 1'b1, 2'd1, 1'b0);
    vecs[7]  = mk(4'b1111, 1'b1, 1'b0, 2'd1, 1'b0);
    vecs[8]  = mk(4'b1111, 1'b0, 1'b1, 2'd2, 1'b0);
    vecs[9]  = mk(4'b1111, 1'b1, 1'b0, 2'd2, 1'b0);
    vecs[10] = mk(4'b1111, 1'b0, 1'b1, 2'd3, 1'b0);
    vecs[11] = mk(4'b1111, 1'b1, 1'b0, 2'd3, 1'b0);
    vecs[12] = mk(4'b1111, 1'b0, 1'b1, 2'd0, 1'b0);
    vecs[13] = mk(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
    vecs[14] = mk(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    vecs[15] = mk(4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
    vecs[16] = mk(4'b0001, 1'b0, 1'b0, 2'd3, 1'b0);
    vecs[17] = mk(4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
    vecs[18] = mk(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    vecs[19] = mk(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);

    // Reset values
    #12;
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      req3_req0 = vecs[i].req;
      done      = vecs[i].dn;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(grant_valid), 32'(vecs[i].vld));
      chk($sformatf("vec%0d_idx", i), 32'(grant_idx), 32'(vecs[i].idx));
      chk($sformatf("vec%0d_timeout", i), 32'(timeout), 32'(vecs[i].to));
    end
    done = 1'b0;

    // Forced release: pointer is 1 here, holder 1 never lets go.
    req3_req0 = 4'b0010;
    step();
    chk("to_grant_valid", 32'(grant_valid), 32'd1);
    chk("to_grant_idx", 32'(grant_idx), 32'd1);
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!grant_valid) break;
      chk("to_no_early_pulse", 32'(timeout), 32'd0);
      hi++;
    end
    chk("to_hold_cycles", 32'(hi), 32'(HM));
    chk("to_pulse", 32'(timeout), 32'd1);
    step();
    chk("to_pulse_clears", 32'(timeout), 32'd0);
    chk("to_regrant_valid", 32'(grant_valid), 32'd1);
    chk("to_regrant_idx", 32'(grant_idx), 32'd1);

    // done on the expiry edge suppresses the timeout pulse
    repeat (HM - 1) step();
    chk("dto_still_held", 32'(grant_valid), 32'd1);
    done = 1'b1;
    step();
    chk("dto_released", 32'(grant_valid), 32'd0);
    chk("dto_no_timeout", 32'(timeout), 32'd0);
    done = 1'b0;

    // Asynchronous reset mid-grant; pointer is 2 after the release of 1.
    req3_req0 = 4'b1111;
    step();
    chk("ar_grant_idx", 32'(grant_idx), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(grant_valid), 32'd0);
    chk("ar_idx", 32'(grant_idx), 32'd0);
    chk("ar_timeout", 32'(timeout), 32'd0);
    #1 reset = 1'b0;
    step();
    chk("ar_post_valid", 32'(grant_valid), 32'd1);
    chk("ar_post_idx", 32'(grant_idx), 32'd0);

    // Exhaustive picker sweep
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < 16; r++) begin
        pk_ptr = 2'(p);
        pk_req = 4'(r);
        #1;
        w = ref_pick(p, 4'(r));
        chk($sformatf("pick_any_p%0d_r%0d", p, r), 32'(pk_any), 32'(w >= 0));
        if (w >= 0) chk($sformatf("pick_idx_p%0d_r%0d", p, r), 32'(pk_idx), 32'(w));
      end
    end

    // Randomized traffic; model starts from the grant of requester 0 above.
    holder = 0;
    m_ptr  = 0;
    held   = 1;
    m_idx  = 2'd0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req3_req0 = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 19) == 0);
      step();
      m_to = 1'b0;
      if (holder < 0) begin
        w = ref_pick(m_ptr, req3_req0);
        if (w >= 0) begin
          holder = w;
          held   = 1;
          m_idx  = 2'(w);
        end
      end else if (done || !req3_req0[holder] || held == HM) begin
        m_to   = !done && req3_req0[holder];
        m_ptr  = (holder + 1) % 4;
        holder = -1;
      end else begin
        held++;
      end
      chk("rnd_valid", 32'(grant_valid), 32'(holder >= 0));
      chk("rnd_idx", 32'(grant_idx), 32'(m_idx));
      chk("rnd_timeout", 32'(timeout), 32'(m_to));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
